xiyiji_program_ctrl: RTL and testbench

//  Washer program sequencer. Sits between the debounce/1 Hz-divider front end and the LED/7-seg display back end.

---
 rtl/xiyiji_program_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_xiyiji_program_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/xiyiji_program_ctrl.sv
// Washer program sequencer: IDLE/INLET/WASH/DRAIN/DRY/DONE/PAUSE on 1 Hz ticks.
// Optional DONE buzzer enabled by defining DONE_BUZZER_EN.
module xiyiji_program_ctrl #(
`ifdef DONE_BUZZER_EN
    parameter int unsigned T_ALARM = 3,
`endif
    parameter int unsigned T_INLET = 5,
    parameter int unsigned T_DRAIN = 5,
    parameter int unsigned T_DRY   = 6,
    parameter int unsigned T_FWD   = 3,
    parameter int unsigned T_REV   = 3,
    parameter int unsigned T_STOP  = 1,
    parameter int unsigned T_WASH0 = 12,
    parameter int unsigned T_WASH1 = 20,
    parameter int unsigned T_WASH2 = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       select_p,
    input  logic       start_p,
    input  logic       emerg_p,
    output logic [1:0] mode,
    output logic [2:0] phase,
    output logic [5:0] count,
    output logic       zheng,
    output logic       fan,
    output logic       inlet,
    output logic       drain,
    output logic       dry,
    output logic       alarm
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INLET = 3'd1,
        WASH  = 3'd2,
        DRAIN = 3'd3,
        DRY   = 3'd4,
        DONE  = 3'd5,
        PAUSE = 3'd6
    } phase_t;

    typedef enum logic [1:0] {
        FWD  = 2'd0,
        STP1 = 2'd1,
        REV  = 2'd2,
        STP2 = 2'd3
    } sub_t;

    phase_t     ph_q, ph_n;
    phase_t     sv_q, sv_n;
    sub_t       sub_q, sub_n;
    logic [5:0] cnt_q, cnt_n;
    logic [5:0] scnt_q, scnt_n;
    logic [1:0] mode_q, mode_n;
`ifdef DONE_BUZZER_EN
    logic [5:0] buzz_q, buzz_n;
`endif

    function automatic logic [1:0] nxt_mode(logic [1:0] m);
        return (m == 2'd2) ? 2'd0 : m + 2'd1;
    endfunction

    function automatic logic [5:0] wash_len(logic [1:0] m);
        unique case (m)
            2'd0:    return 6'(T_WASH0);
            2'd1:    return 6'(T_WASH1);
            default: return 6'(T_WASH2);
        endcase
    endfunction

    function automatic logic [5:0] sub_len(sub_t s);
        unique case (s)
            FWD:     return 6'(T_FWD);
            REV:     return 6'(T_REV);
            default: return 6'(T_STOP);
        endcase
    endfunction

    assign mode  = mode_q;
    assign phase = ph_q;
    assign count = cnt_q;

    // Next-state: phase transitions, counters, pause save/restore.
    always_comb begin
        ph_n   = ph_q;
        sv_n   = sv_q;
        sub_n  = sub_q;
        cnt_n  = cnt_q;
        scnt_n = scnt_q;
        mode_n = mode_q;
`ifdef DONE_BUZZER_EN
        buzz_n = buzz_q;
`endif
        unique case (ph_q)
            IDLE: begin
                if (start_p) begin
                    ph_n  = INLET;
                    cnt_n = 6'(T_INLET);
                end else if (select_p) begin
                    mode_n = nxt_mode(mode_q);
                end
            end
            INLET, WASH, DRAIN, DRY: begin
                if (emerg_p) begin
                    ph_n = PAUSE;
                    sv_n = ph_q;
                end else if (tick_1hz) begin
                    if (ph_q == WASH) begin
                        if (scnt_q == 6'd1) begin
                            sub_n  = sub_t'(sub_q + 2'd1);
                            scnt_n = sub_len(sub_t'(sub_q + 2'd1));
                        end else begin
                            scnt_n = scnt_q - 6'd1;
                        end
                    end
                    if (cnt_q != 6'd1) begin
                        cnt_n = cnt_q - 6'd1;
                    end else if (ph_q == INLET) begin
                        ph_n   = WASH;
                        cnt_n  = wash_len(mode_q);
                        sub_n  = FWD;
                        scnt_n = 6'(T_FWD);
                    end else if (ph_q == WASH) begin
                        ph_n  = DRAIN;
                        cnt_n = 6'(T_DRAIN);
                    end else if (ph_q == DRAIN) begin
                        ph_n  = DRY;
                        cnt_n = 6'(T_DRY);
                    end else begin
                        ph_n  = DONE;
                        cnt_n = 6'd0;
`ifdef DONE_BUZZER_EN
                        buzz_n = 6'(T_ALARM);
`endif
                    end
                end
            end
            DONE: begin
                if (start_p) begin
                    ph_n  = INLET;
                    cnt_n = 6'(T_INLET);
`ifdef DONE_BUZZER_EN
                    buzz_n = 6'd0;
`endif
                end else if (select_p) begin
                    ph_n   = IDLE;
                    mode_n = nxt_mode(mode_q);
`ifdef DONE_BUZZER_EN
                    buzz_n = 6'd0;
`endif
                end
`ifdef DONE_BUZZER_EN
                else if (tick_1hz && buzz_q != 6'd0) begin
                    buzz_n = buzz_q - 6'd1;
                end
`endif
            end
            PAUSE: begin
                if (start_p) begin
                    ph_n = sv_q;
                end
            end
            default: ph_n = IDLE;
        endcase
    end

    // State and registered actuator/alarm outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ph_q   <= IDLE;
            sv_q   <= IDLE;
            sub_q  <= FWD;
            cnt_q  <= 6'd0;
            scnt_q <= 6'd0;
            mode_q <= 2'd0;
            zheng  <= 1'b0;
            fan    <= 1'b0;
            inlet  <= 1'b0;
            drain  <= 1'b0;
            dry    <= 1'b0;
            alarm  <= 1'b0;
`ifdef DONE_BUZZER_EN
            buzz_q <= 6'd0;
`endif
        end else begin
            ph_q   <= ph_n;
            sv_q   <= sv_n;
            sub_q  <= sub_n;
            cnt_q  <= cnt_n;
            scnt_q <= scnt_n;
            mode_q <= mode_n;
            zheng  <= (ph_n == WASH) && (sub_n == FWD);
            fan    <= (ph_n == WASH) && (sub_n == REV);
            inlet  <= (ph_n == INLET);
            drain  <= (ph_n == DRAIN);
            dry    <= (ph_n == DRY);
`ifdef DONE_BUZZER_EN
            buzz_q <= buzz_n;
            alarm  <= (ph_n == PAUSE) ||
                      ((ph_n == DONE) && (buzz_n != 6'd0));
`else
            alarm  <= (ph_n == PAUSE);
`endif
        end
    end

endmodule

// File: tb/tb_xiyiji_program_ctrl.sv
// Scoreboard bench for xiyiji_program_ctrl.
// Reference model tracks phase and remaining seconds; wash direction is derived arithmetically.
module tb_xiyiji_program_ctrl;

    localparam int TI = 5, TD = 5, TY = 6;
    localparam int TF = 3, TR = 3, TS = 1;
    localparam int TA = 3;
    localparam int CYC = TF + TS + TR + TS;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       select_p = 1'b0;
    logic       start_p = 1'b0;
    logic       emerg_p = 1'b0;
    logic [1:0] mode;
    logic [2:0] phase;
    logic [5:0] count;
    logic       zheng, fan, inlet, drain, dry, alarm;

    xiyiji_program_ctrl dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
        .select_p(select_p), .start_p(start_p), .emerg_p(emerg_p),
        .mode(mode), .phase(phase), .count(count),
        .zheng(zheng), .fan(fan), .inlet(inlet),
        .drain(drain), .dry(dry), .alarm(alarm)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [16:0] exp_q[$];
    logic [16:0] m_ex, m_ac;

    int m_ph = 0, m_sv = 0, m_cnt = 0, m_mode = 0, m_buzz = 0;

    function automatic int wlen(int m);
        return (m == 0) ? 12 : (m == 1) ? 20 : 30;
    endfunction

    function automatic logic [16:0] expect_out();
        int e, p;
        bit z, f, a;
        z = 0;
        f = 0;
        if (m_ph == 2) begin
            e = wlen(m_mode) - m_cnt;
            p = e % CYC;
            z = (p < TF);
            f = (p >= TF + TS) && (p < TF + TS + TR);
        end
        a = (m_ph == 6);
`ifdef DONE_BUZZER_EN
        if (m_ph == 5 && m_buzz > 0) a = 1;
`endif
        return {2'(m_mode), 3'(m_ph), 6'(m_cnt), z, f,
                m_ph == 1, m_ph == 3, m_ph == 4, a};
    endfunction

    task automatic model(bit r, bit t, bit s, bit st, bit e);
        if (!r) begin
            m_ph = 0; m_sv = 0; m_cnt = 0; m_mode = 0; m_buzz = 0;
        end else begin
            case (m_ph)
                0: if (st) begin
                    m_ph = 1; m_cnt = TI;
                end else if (s) m_mode = (m_mode + 1) % 3;
                1, 2, 3, 4: if (e) begin
                    m_sv = m_ph; m_ph = 6;
                end else if (t) begin
                    if (m_cnt > 1) m_cnt--;
                    else begin
                        m_ph++;
                        m_cnt = (m_ph == 2) ? wlen(m_mode) :
                                (m_ph == 3) ? TD :
                                (m_ph == 4) ? TY : 0;
                        if (m_ph == 5) m_buzz = TA;
                    end
                end
                5: if (st) begin
                    m_ph = 1; m_cnt = TI; m_buzz = 0;
                end else if (s) begin
                    m_ph = 0; m_mode = (m_mode + 1) % 3; m_buzz = 0;
                end else if (t && m_buzz > 0) m_buzz--;
                6: if (st) m_ph = m_sv;
                default: m_ph = 0;
            endcase
        end
    endtask

    task automatic step(bit r, bit t, bit s, bit st, bit e);
        @(negedge clk);
        rst = r;
        tick_1hz = t;
        select_p = s;
        start_p = st;
        emerg_p = e;
        model(r, t, s, st, e);
        exp_q.push_back(expect_out());
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) begin
            step(1, 1, 0, 0, 0);
            step(1, 0, 0, 0, 0);
        end
    endtask

    // Monitor: every edge after stimulus presents a registered output.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                m_ex = exp_q.pop_front();
                m_ac = {mode, phase, count, zheng, fan,
                        inlet, drain, dry, alarm};
                n_cmp++;
                if (m_ac !== m_ex) begin
                    n_err++;
                    $display("FAIL outputs t=%0t act=%h exp=%h",
                             $time, m_ac, m_ex);
                end
            end
        end
    end

    initial begin
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 0, 0);
            idle(1);
        end
        step(1, 0, 1, 1, 0);
        ticks(32);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0);
        ticks(10);
        step(1, 0, 0, 0, 1);
        ticks(10);
        step(1, 0, 1, 0, 1);
        step(1, 0, 0, 1, 0);
        ticks(16);
        step(1, 0, 0, 1, 1);
        ticks(3);
        step(1, 0, 0, 1, 0);
        ticks(16);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1);
        idle(2);
        step(1, 0, 0, 1, 0);
        ticks(42);
        step(0, 0, 0, 0, 0);
        idle(3);
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 399) != 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 29) == 0);
        end
        idle(1);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain act=%0d exp=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
